cordic_iter_engine: RTL and testbench
=====================================

Name: cordic_iter_engine

Overview:
- Parametrised, self-sequencing iterative CORDIC core; successor to the single-step recon datapath.
- Accepts one (X,Y,Z) operand set per start handshake and runs the micro-rotation iterations internally, one per clock, using its own FSM and iteration counter.
- Supports linear, circular and hyperbolic coordinates, each in rotation or vectoring mode.
- Angle constants come combinationally from an external ROM addressed by this block. Sits between the NN layer controller (operand issue) and the activation/accumulate stage.

Parameters:
- WIDTH, 16: datapath width; all X/Y/Z are signed two's complement.
- FRAC, 13: fractional bits of the fixed-point format; informational, used by the bench only.
- ITERS, 14: number of base iterations, minimum 1 and maximum 2**IW-1.
- IW, 4: width of the iteration index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to launch an operation; accepted only while ready=1.
- ready  out  1  high in IDLE.
- coord  in  2  coordinate system: 00 linear, 01 circular, 10 hyperbolic, 11 treated as circular. Sampled on accept.
- vec  in  1  0 = rotation (drive Z to 0), 1 = vectoring (drive Y to 0). Sampled on accept.
- x_in, y_in, z_in  in  WIDTH each  initial operands, sampled on accept.
- iter_idx  out  IW  current shift index; address to the external ROM.
- coord_q  out  2  latched coord; address to the external ROM.
- z_rom  in  WIDTH  angle constant for (coord_q, iter_idx), combinational from the ROM, used in the same cycle.
- busy  out  1  high in ITER.
- valid_out  out  1  one-cycle pulse when results are final.
- x_out, y_out, z_out  out  WIDTH each  results; held until the next accept.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - ready=1; busy=0; valid_out=0.
  - x_out/y_out/z_out=0; internal X/Y/Z registers=0; iter_idx=0; coord_q=01.
  - Reset mid-operation aborts with no valid_out.
- FSM states: IDLE, ITER, DONE.
  - IDLE: on a rising edge with start=1, load X/Y/Z, coord_q and vec, and go to ITER.
    - iter_idx starts at 1 for hyperbolic, otherwise at 0.
  - ITER: one micro-rotation per rising edge. Leave for DONE after the last iteration.
  - DONE: copy X/Y/Z to x_out/y_out/z_out, assert valid_out for this cycle, then return to IDLE.
- start while busy or in DONE is ignored; no queueing.
- Iteration counts:
  - Linear and circular: indices 0..ITERS-1, giving N=ITERS cycles.
  - Hyperbolic: indices 1..ITERS, with indices 4, 13 and 40 executed twice when they are ≤ ITERS. A repeat-pending flag holds iter_idx for one extra cycle. N = ITERS + number of repeats.
- Latency: the accept edge is cycle 0; valid_out is high during cycle N+1. The next accept is possible in cycle N+2.
- Direction d (+1/-1), from the current registers:
  - Rotation: d=+1 if Z[WIDTH-1]=0, else -1.
  - Vectoring: d=+1 if Y[WIDTH-1]=1, else -1.
- Per-iteration update, all computed from the old values:
  - X' = X − μ·d·(Y>>>i), with μ = +1 circular, 0 linear, −1 hyperbolic.
  - Y' = Y + d·(X>>>i).
  - Z' = Z − d·z_rom.
- Arithmetic rules:
  - >>> is an arithmetic shift.
  - A shift ≥ WIDTH yields all sign bits.
  - Add/sub wraps modulo 2**WIDTH; no saturation and no overflow flag.
- No gain compensation: the caller pre-scales by K (circular) or K_h (hyperbolic).
- x_out/y_out/z_out change only in DONE.

Test Plan:
1. Circular rotation, ITERS=14, FRAC=13.
   - Stimulus: x_in=0x136F (K), y_in=0, z_in=0x1922 (π/4).
   - Required: x_out ≈ y_out ≈ 0x16A1 within ±4 LSB, z_out within ±4 LSB of 0. valid_out is high exactly 15 cycles after the accept edge, for one cycle.
2. Circular vectoring.
   - Stimulus: x_in=0x2000, y_in=0x2000, z_in=0.
   - Required: z_out ≈ 0x1922 ±4, x_out ≈ 0x4A86 ±6, y_out within ±4 of 0.
3. Linear rotation (multiply).
   - Stimulus: x_in=0x2000, y_in=0, z_in=0x1000.
   - Required: x_out=0x2000 exactly, y_out ≈ 0x1000 ±2, N=14.
4. Hyperbolic rotation, ITERS=14.
   - Required: iter_idx sequence 1,2,3,4,4,5..13,13,14 (16 cycles); valid_out 17 cycles after accept. Results match the bench's bit-accurate model exactly.
5. Handshake.
   - Stimulus: start held high for 40 cycles.
   - Required: accepts only in IDLE, one result per 16 cycles (circular), operands changed mid-run have no effect, and ready=0 while busy.
6. Reset mid-run.
   - Stimulus: drop rst_n at iteration 7.
   - Required: all outputs 0 immediately, no valid_out, ready=1 after release, and the next operation is correct.

Source files
------------

// File: rtl/cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// cordic_iter_engine
//
// Self-sequencing iterative CORDIC core. One (X,Y,Z) operand set is accepted
// per start handshake. The core then runs one micro-rotation per clock until the
// iteration schedule for the latched coordinate system is complete. Linear,
// circular and hyperbolic coordinates are supported, each in rotation mode
// (drive Z to 0) or vectoring mode (drive Y to 0). Gain compensation is the
// caller's job.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      launch request, taken only while ready=1
//   ready      high while IDLE
//   coord      00 linear, 01 circular, 10 hyperbolic, 11 circular (sampled on accept)
//   vec        0 rotation, 1 vectoring (sampled on accept)
//   x_in/y_in/z_in   initial operands (sampled on accept)
//   iter_idx   current shift index, address to the external angle ROM
//   coord_q    latched coordinate system, address to the external angle ROM
//   z_rom      angle constant for (coord_q, iter_idx), used in the same cycle
//   busy       high while iterating
//   valid_out  one-cycle pulse while x_out/y_out/z_out carry fresh results
//   x_out/y_out/z_out  results, held until the next operation completes
// -----------------------------------------------------------------------------
module cordic_iter_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 13,
  parameter int ITERS = 14,
  parameter int IW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       coord,
  input  logic             vec,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic [IW-1:0]    iter_idx,
  output logic [1:0]       coord_q,
  input  logic [WIDTH-1:0] z_rom,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out
);

  // Reject parameter sets the index width or number format cannot represent.
  if ((ITERS < 1) || (ITERS > (2 ** IW) - 1) || (FRAC >= WIDTH)) begin : g_param_check
    $error("cordic_iter_engine: illegal WIDTH/FRAC/ITERS/IW combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic [1:0]              coord_d;
  logic                    vec_q, vec_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    rep_q, rep_d;

  logic signed [WIDTH-1:0] x_shift, y_shift, z_rom_s;
  logic signed [WIDTH-1:0] x_step, y_step, z_step;
  logic                    is_lin, is_hyp, d_pos;
  logic [31:0]             idx_ext;
  logic                    rep_idx, last_iter;

  assign ready     = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_ITER);
  assign valid_out = (state_q == ST_DONE);
  assign iter_idx  = idx_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

  // One micro-rotation from the current registers. Shifts are arithmetic, and
  // all add/sub results simply wrap at WIDTH bits.
  always_comb begin
    is_lin  = (coord_q == 2'b00);
    is_hyp  = (coord_q == 2'b10);
    x_shift = x_q >>> idx_q;
    y_shift = y_q >>> idx_q;
    z_rom_s = $signed(z_rom);

    // d=+1 drives Z toward zero in rotation, or Y toward zero in vectoring.
    d_pos   = vec_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];

    y_step  = d_pos ? (y_q + x_shift) : (y_q - x_shift);
    z_step  = d_pos ? (z_q - z_rom_s) : (z_q + z_rom_s);

    // X term carries mu: +1 circular (subtract), 0 linear, -1 hyperbolic (add).
    if (is_lin) begin
      x_step = x_q;
    end else if (is_hyp) begin
      x_step = d_pos ? (x_q + y_shift) : (x_q - y_shift);
    end else begin
      x_step = d_pos ? (x_q - y_shift) : (x_q + y_shift);
    end
  end

  // Iteration schedule. Hyperbolic runs indices 1..ITERS and repeats 4, 13 and
  // 40 once each for convergence; rep_q marks that the repeat is being executed
  // so the index is held for exactly one extra cycle.
  always_comb begin
    idx_ext = {{(32 - IW){1'b0}}, idx_q};
    rep_idx = is_hyp && ((idx_ext == 32'd4) || (idx_ext == 32'd13) || (idx_ext == 32'd40));
    if (is_hyp) begin
      last_iter = (idx_ext == 32'(ITERS)) && (!rep_idx || rep_q);
    end else begin
      last_iter = (idx_ext == 32'(ITERS - 1));
    end
  end

  // Next-state logic. Results are captured on the edge into DONE so that
  // x_out/y_out/z_out are already valid while valid_out is high.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    coord_d = coord_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          coord_d = coord;
          vec_d   = vec;
          idx_d   = (coord == 2'b10) ? IW'(1) : IW'(0);
          rep_d   = 1'b0;
          state_d = ST_ITER;
        end
      end

      ST_ITER: begin
        x_d = x_step;
        y_d = y_step;
        z_d = z_step;
        if (last_iter) begin
          x_out_d = x_step;
          y_out_d = y_step;
          z_out_d = z_step;
          rep_d   = 1'b0;
          state_d = ST_DONE;
        end else if (rep_idx && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
          rep_d = 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      coord_q <= 2'b01;
      vec_q   <= 1'b0;
      idx_q   <= '0;
      rep_q   <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      coord_q <= coord_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_iter_engine
//
// Self-checking bench for cordic_iter_engine. Provides the external angle ROM,
// and holds a reference model that builds the iteration index list from the
// coordinate rules and runs the micro-rotations with integer arithmetic.
// -----------------------------------------------------------------------------
module tb_cordic_iter_engine;

  localparam int WIDTH = 16;
  localparam int FRAC  = 13;
  localparam int ITERS = 14;
  localparam int IW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic [1:0]       coord;
  logic             vec;
  logic [WIDTH-1:0] x_in, y_in, z_in;
  logic [IW-1:0]    iter_idx;
  logic [1:0]       coord_q;
  logic [WIDTH-1:0] z_rom;
  logic             busy;
  logic             valid_out;
  logic [WIDTH-1:0] x_out, y_out, z_out;

  // Angle ROMs: linear 2^-i, circular atan(2^-i), hyperbolic atanh(2^-i).
  logic [WIDTH-1:0] rom_lin [16];
  logic [WIDTH-1:0] rom_cir [16];
  logic [WIDTH-1:0] rom_hyp [16];

  int total = 0;
  int bad   = 0;
  int expIdx[$];
  logic [WIDTH-1:0] prevX = '0, prevY = '0, prevZ = '0;

  cordic_iter_engine #(
    .WIDTH(WIDTH), .FRAC(FRAC), .ITERS(ITERS), .IW(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .coord(coord), .vec(vec), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .iter_idx(iter_idx), .coord_q(coord_q), .z_rom(z_rom),
    .busy(busy), .valid_out(valid_out),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  assign z_rom = (coord_q == 2'b00) ? rom_lin[iter_idx] :
                 (coord_q == 2'b10) ? rom_hyp[iter_idx] : rom_cir[iter_idx];

  // Safety net in case anything below stops making progress.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkNear(input string tag, input logic [WIDTH-1:0] obs, input int exp, input int tol);
    int o, diff;
    o    = int'($signed(obs));
    diff = (o > exp) ? (o - exp) : (exp - o);
    total++;
    assert (diff <= tol) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d+-%0d", tag, o, exp, tol);
    end
  endtask

  function automatic int wrapW(int v);
    logic signed [WIDTH-1:0] t;
    t = v[WIDTH-1:0];
    return int'(t);
  endfunction

  function automatic int romVal(logic [1:0] c, int k);
    logic [WIDTH-1:0] r;
    if (c == 2'b00)      r = rom_lin[k];
    else if (c == 2'b10) r = rom_hyp[k];
    else                 r = rom_cir[k];
    return int'($signed(r));
  endfunction

  // Reference: index list from the coordinate rules, then plain integer CORDIC.
  task automatic modelRun(input logic [1:0] c, input logic v,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z,
                          output logic [WIDTH-1:0] ex, output logic [WIDTH-1:0] ey, output logic [WIDTH-1:0] ez,
                          output int n);
    int seq[$];
    int xi, yi, zi, nx, ny, nz, d, mu, k;
    seq.delete();
    if (c == 2'b10) begin
      for (int i = 1; i <= ITERS; i++) begin
        seq.push_back(i);
        if (i == 4 || i == 13 || i == 40) seq.push_back(i);
      end
    end else begin
      for (int i = 0; i < ITERS; i++) seq.push_back(i);
    end
    mu = (c == 2'b00) ? 0 : (c == 2'b10) ? -1 : 1;
    xi = int'($signed(x));
    yi = int'($signed(y));
    zi = int'($signed(z));
    foreach (seq[j]) begin
      k  = seq[j];
      d  = v ? ((yi < 0) ? 1 : -1) : ((zi >= 0) ? 1 : -1);
      nx = wrapW(xi - mu * d * (yi >>> k));
      ny = wrapW(yi + d * (xi >>> k));
      nz = wrapW(zi - d * romVal(c, k));
      xi = nx;
      yi = ny;
      zi = nz;
    end
    expIdx = seq;
    n  = seq.size();
    ex = xi[WIDTH-1:0];
    ey = yi[WIDTH-1:0];
    ez = zi[WIDTH-1:0];
  endtask

  // Waits for IDLE, presents operands with start, then scrambles them after accept.
  task automatic applyStimulus(input logic [1:0] c, input logic v,
                               input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
    for (int g = 0; g < 40 && !ready; g++) tick();
    checkOutput("ready before accept", 32'(ready), 32'd1);
    coord = c; vec = v; x_in = x; y_in = y; z_in = z;
    start = 1'b1;
    tick();
    start = 1'b0;
    coord = 2'($urandom); vec = 1'($urandom);
    x_in = WIDTH'($urandom); y_in = WIDTH'($urandom); z_in = WIDTH'($urandom);
  endtask

  task automatic runOp(input string tag, input logic [1:0] c, input logic v,
                       input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z,
                       output int lat);
    logic [WIDTH-1:0] ex, ey, ez;
    int n, cyc;
    bit seen;
    modelRun(c, v, x, y, z, ex, ey, ez, n);
    applyStimulus(c, v, x, y, z);
    checkOutput($sformatf("%s busy", tag), 32'(busy), 32'd1);
    checkOutput($sformatf("%s ready low", tag), 32'(ready), 32'd0);
    checkOutput($sformatf("%s x_out held", tag), 32'(x_out), 32'(prevX));
    checkOutput($sformatf("%s z_out held", tag), 32'(z_out), 32'(prevZ));
    cyc  = 1;
    seen = 0;
    while (cyc <= n + 6) begin
      if (valid_out) begin
        seen = 1;
        break;
      end
      if (cyc <= n)
        checkOutput($sformatf("%s idx c%0d", tag, cyc), 32'(iter_idx), 32'(expIdx[cyc-1]));
      tick();
      cyc++;
    end
    lat = seen ? cyc : -1;
    checkOutput($sformatf("%s latency", tag), 32'(lat), 32'(n + 1));
    checkOutput($sformatf("%s x_out", tag), 32'(x_out), 32'(ex));
    checkOutput($sformatf("%s y_out", tag), 32'(y_out), 32'(ey));
    checkOutput($sformatf("%s z_out", tag), 32'(z_out), 32'(ez));
    prevX = ex; prevY = ey; prevZ = ez;
    tick();
    checkOutput($sformatf("%s valid one cycle", tag), 32'(valid_out), 32'd0);
    checkOutput($sformatf("%s ready after", tag), 32'(ready), 32'd1);
  endtask

  initial begin
    real p, scale;
    int lat, accepts, lastAcc, n;
    logic [WIDTH-1:0] ex, ey, ez;
    logic [WIDTH-1:0] qx[$], qy[$], qz[$];
    logic qv[$];
    int qc[$];

    scale = 1.0;
    for (int i = 0; i < FRAC; i++) scale = scale * 2.0;
    p = 1.0;
    for (int i = 0; i < 16; i++) begin
      rom_lin[i] = WIDTH'($rtoi(p * scale + 0.5));
      rom_cir[i] = WIDTH'($rtoi($atan(p) * scale + 0.5));
      rom_hyp[i] = (i == 0) ? '0 : WIDTH'($rtoi(0.5 * $ln((1.0 + p) / (1.0 - p)) * scale + 0.5));
      p = p / 2.0;
    end

    rst_n = 1'b0; start = 1'b0; coord = 2'b00; vec = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    tick(); tick();
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset valid", 32'(valid_out), 32'd0);
    checkOutput("reset x_out", 32'(x_out), 32'd0);
    checkOutput("reset iter_idx", 32'(iter_idx), 32'd0);
    checkOutput("reset coord_q", 32'(coord_q), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("[TB] circular rotation");
    runOp("circ rot", 2'b01, 1'b0, 16'h136F, 16'h0000, 16'h1922, lat);
    checkOutput("circ rot latency 15", 32'(lat), 32'd15);
    checkNear("circ rot x", prevX, 16'h16A1, 4);
    checkNear("circ rot y", prevY, 16'h16A1, 4);
    checkNear("circ rot z", prevZ, 0, 4);

    $display("[TB] circular vectoring");
    runOp("circ vec", 2'b01, 1'b1, 16'h2000, 16'h2000, 16'h0000, lat);
    checkNear("circ vec z", prevZ, 16'h1922, 4);
    checkNear("circ vec x", prevX, 16'h4A86, 6);
    checkNear("circ vec y", prevY, 0, 4);

    $display("[TB] linear rotation");
    runOp("lin rot", 2'b00, 1'b0, 16'h2000, 16'h0000, 16'h1000, lat);
    checkOutput("lin rot latency", 32'(lat), 32'd15);
    checkOutput("lin rot x exact", 32'(prevX), 32'h2000);
    checkNear("lin rot y", prevY, 16'h1000, 2);

    $display("[TB] hyperbolic rotation");
    runOp("hyp rot", 2'b10, 1'b0, 16'h26A4, 16'h0000, 16'h0800, lat);
    checkOutput("hyp rot latency 17", 32'(lat), 32'd17);

    $display("[TB] randomized operations");
    for (int r = 0; r < 24; r++)
      runOp($sformatf("rand%0d", r), 2'($urandom), 1'($urandom),
            WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), lat);

    $display("[TB] handshake with start held high");
    accepts = 0;
    lastAcc = -1;
    coord   = 2'b01;
    start   = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 40) start = 1'b0;
      vec  = 1'($urandom);
      x_in = WIDTH'($urandom); y_in = WIDTH'($urandom); z_in = WIDTH'($urandom);
      if (busy) checkOutput("hs ready low while busy", 32'(ready), 32'd0);
      if (valid_out) begin
        if (qc.size() == 0) begin
          checkOutput("hs unexpected valid", 32'd1, 32'd0);
        end else begin
          modelRun(2'b01, qv[0], qx[0], qy[0], qz[0], ex, ey, ez, n);
          checkOutput("hs latency", 32'(cyc - qc[0]), 32'd15);
          checkOutput("hs x_out", 32'(x_out), 32'(ex));
          checkOutput("hs y_out", 32'(y_out), 32'(ey));
          checkOutput("hs z_out", 32'(z_out), 32'(ez));
          prevX = ex; prevY = ey; prevZ = ez;
          void'(qx.pop_front()); void'(qy.pop_front()); void'(qz.pop_front());
          void'(qv.pop_front()); void'(qc.pop_front());
        end
      end
      if (ready && start) begin
        if (lastAcc >= 0) checkOutput("hs accept spacing", 32'(cyc - lastAcc), 32'd16);
        qx.push_back(x_in); qy.push_back(y_in); qz.push_back(z_in);
        qv.push_back(vec); qc.push_back(cyc);
        lastAcc = cyc;
        accepts++;
      end
      tick();
    end
    checkOutput("hs accept count", 32'(accepts), 32'd3);
    checkOutput("hs all results seen", 32'(qc.size()), 32'd0);

    $display("[TB] reset in the middle of a run");
    applyStimulus(2'b10, 1'b0, 16'h26A4, 16'h0100, 16'h0400);
    for (int g = 0; g < 20 && iter_idx != IW'(7); g++) tick();
    checkOutput("mid reset reached idx 7", 32'(iter_idx), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset x_out", 32'(x_out), 32'd0);
    checkOutput("mid reset y_out", 32'(y_out), 32'd0);
    checkOutput("mid reset z_out", 32'(z_out), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset ready", 32'(ready), 32'd1);
    checkOutput("mid reset iter_idx", 32'(iter_idx), 32'd0);
    checkOutput("mid reset coord_q", 32'(coord_q), 32'd1);
    for (int g = 0; g < 3; g++) begin
      tick();
      checkOutput("mid reset no valid", 32'(valid_out), 32'd0);
    end
    rst_n = 1'b1;
    prevX = '0; prevY = '0; prevZ = '0;
    tick();
    checkOutput("after reset ready", 32'(ready), 32'd1);
    runOp("post reset", 2'b01, 1'b0, 16'h136F, 16'h0000, 16'hF000, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
